// File: rtl/ifetch_sequencer.sv
// Instruction-fetch controller for the single-cycle LEGv8 core: owns the pc, drives the
// instruction ROM and hands words to the decoder. Optional counter: IFETCH_FETCH_COUNT_EN.
module ifetch_sequencer #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'hD60003E0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_kind,
  input  logic [ADDR_W-1:0]  redirect_base,
  input  logic [25:0]        redirect_imm,
  input  logic [63:0]        redirect_reg,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               halted_q, halted_d;
  logic [ADDR_W-1:0]  target_c;
  logic               load_c;

  // Only the word-address bits of the BR register value matter.
  logic unused_redirect_reg;
  assign unused_redirect_reg = ^{redirect_reg[63:ADDR_W+2], redirect_reg[1:0]};

  // Branch target; adds wrap modulo 2^ADDR_W.
  always_comb begin
    target_c = pc_q;
    case (redirect_kind)
      2'b00:   target_c = redirect_base + ADDR_W'($signed(redirect_imm));
      2'b01:   target_c = redirect_base + ADDR_W'($signed(redirect_imm[18:0]));
      2'b10:   target_c = redirect_reg[ADDR_W+1:2];
      default: target_c = pc_q;
    endcase
  end

  // Next-state and output logic; redirect outranks load, stall and halt detection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    load_c        = (!instr_valid_q || instr_ready) && !redirect_valid;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = target_c;
        end else if (load_c) begin
          if (rom_data == HALT_WORD) begin
            instr_valid_d = 1'b0;
            state_d       = S_HALT;
          end else begin
            instr_d       = rom_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDR_W'(1);
          end
        end
      end
      S_HALT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = S_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign rom_address = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

`ifdef IFETCH_FETCH_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Saturating count of accepted instructions.
  always_comb begin
    count_d = count_q;
    if (instr_valid_q && instr_ready && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Self-checking bench for ifetch_sequencer: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ifetch_sequencer;

  localparam logic [31:0] HALT = 32'hD60003E0;
`ifdef IFETCH_FETCH_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, instr_ready, redirect_valid;
  logic [1:0]  redirect_kind;
  logic [15:0] redirect_base;
  logic [25:0] redirect_imm;
  logic [63:0] redirect_reg;
  logic [15:0] rom_address, instr_pc;
  logic [31:0] rom_data, instr, fetch_count;
  logic        instr_valid, halted;

  logic [31:0] rom [0:65535];
  assign rom_data = rom[rom_address];

  ifetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_address(rom_address), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm), .redirect_reg(redirect_reg),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 fetching, 2 halted; next address and the held instruction.
  int          m_st;
  logic [15:0] m_pc, m_ipc;
  logic [31:0] m_instr, m_cnt;
  logic        m_v;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] branch_target(input logic [1:0] k, input logic [15:0] b,
                                                input logic [25:0] imm, input logic [63:0] r,
                                                input logic [15:0] pc);
    int off;
    case (k)
      2'd0: begin
        off = int'(imm);
        if (imm[25]) off -= (1 << 26);
        return 16'(int'(b) + off);
      end
      2'd1: begin
        off = int'(imm[18:0]);
        if (imm[18]) off -= (1 << 19);
        return 16'(int'(b) + off);
      end
      2'd2: return 16'(r / 64'd4);
      default: return pc;
    endcase
  endfunction

  task automatic model_update();
    logic hs;
    hs = m_v && instr_ready;
    if (reset) begin
      m_st = 0; m_pc = '0; m_ipc = '0; m_instr = '0; m_v = 1'b0; m_cnt = '0;
    end else begin
      if (COUNT_EN && hs && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      case (m_st)
        0: if (start) m_st = 1;
        1: begin
          if (redirect_valid) begin
            m_v  = 1'b0;
            m_pc = branch_target(redirect_kind, redirect_base, redirect_imm, redirect_reg, m_pc);
          end else if (!m_v || instr_ready) begin
            if (rom[m_pc] == HALT) begin
              m_v = 1'b0; m_st = 2;
            end else begin
              m_instr = rom[m_pc]; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("rom_address", 64'(rom_address), 64'(m_pc));
    chk("instr_valid", 64'(instr_valid), 64'(m_v));
    chk("halted", 64'(halted), 64'(m_st == 2));
    chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
    if (m_v) begin
      chk("instr", 64'(instr), 64'(m_instr));
      chk("instr_pc", 64'(instr_pc), 64'(m_ipc));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    check_all();
  endtask

  task automatic run_until(input logic [15:0] ipc, input int budget);
    int n;
    n = 0;
    while (!(m_v && m_ipc == ipc) && n < budget) begin
      step();
      n++;
    end
    chk("reach_valid", 64'(instr_valid), 64'd1);
    chk("reach_ipc", 64'(instr_pc), 64'(ipc));
  endtask

  task automatic redirect(input logic [1:0] k, input logic [15:0] b, input logic [25:0] imm,
                          input logic [63:0] r);
    redirect_valid = 1'b1; redirect_kind = k; redirect_base = b;
    redirect_imm = imm; redirect_reg = r;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1; start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_kind = 2'd0; redirect_base = '0; redirect_imm = '0; redirect_reg = '0;
    m_st = 0; m_pc = '0; m_ipc = '0; m_instr = '0; m_v = 1'b0; m_cnt = '0;
    for (int i = 0; i < 65536; i++) begin
      w = $urandom;
      if (w == HALT) w = w ^ 32'h1;
      rom[i] = w;
    end
    for (int i = 0; i < 10; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[10] = HALT;

    // Reset values, then IDLE holds without start.
    step(); step();
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    reset = 1'b0;
    step();
    chk("idle_pc", 64'(rom_address), 64'd0);

    // Sequential fetch 0..9 then the halt word at 10.
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    chk("seq_halted", 64'(halted), 64'd1);
    chk("seq_pc", 64'(rom_address), 64'd10);
`ifdef IFETCH_FETCH_COUNT_EN
    chk("seq_count", 64'(fetch_count), 64'd10);
`endif
    start = 1'b1; redirect_valid = 1'b1; redirect_kind = 2'd2; redirect_reg = 64'h100;
    step();
    start = 1'b0; redirect_valid = 1'b0;
    chk("halt_sticky", 64'(halted), 64'd1);

    // Stall at instr_pc 4.
    reset = 1'b1; step(); reset = 1'b0;
    rom[10] = 32'hA000_000A;
    start = 1'b1; step(); start = 1'b0;
    run_until(16'd4, 20);
    instr_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_ipc", 64'(instr_pc), 64'd4);
      chk("stall_pc", 64'(rom_address), 64'd5);
    end
    instr_ready = 1'b1;
    step();
    chk("after_stall_ipc", 64'(instr_pc), 64'd5);

    // B -7 while instr_pc 10 is valid.
    run_until(16'd10, 20);
    redirect(2'd0, 16'd9, 26'h3FFFFF9, 64'd0);
    chk("b_flush", 64'(instr_valid), 64'd0);
    chk("b_target", 64'(rom_address), 64'd2);
    step();
    chk("b_valid", 64'(instr_valid), 64'd1);
    chk("b_ipc", 64'(instr_pc), 64'd2);

    // CBZ, BR, reserved kind.
    redirect(2'd1, 16'd3, 26'd6, 64'd0);
    chk("cbz_pc", 64'(rom_address), 64'd9);
    redirect(2'd2, 16'd0, 26'd0, 64'd0);
    chk("br_pc", 64'(rom_address), 64'd0);
    step();
    redirect(2'd3, 16'd7, 26'd5, 64'h80);
    chk("rsv_pc", 64'(rom_address), 64'd1);
    chk("rsv_flush", 64'(instr_valid), 64'd0);

    // Redirect beats halt detection; base + imm wraps; pc increment wraps.
    w = rom[1];
    rom[1] = HALT;
    redirect(2'd0, 16'd5, 26'd2, 64'd0);
    rom[1] = w;
    chk("prio_halted", 64'(halted), 64'd0);
    chk("prio_pc", 64'(rom_address), 64'd7);
    redirect(2'd0, 16'hFFFE, 26'd3, 64'd0);
    chk("wrap_add_pc", 64'(rom_address), 64'd1);
    redirect(2'd2, 16'd0, 26'd0, 64'h3FFFC);
    chk("br_ffff", 64'(rom_address), 64'hFFFF);
    step();
    chk("wrap_inc_pc", 64'(rom_address), 64'd0);
    chk("wrap_ipc", 64'(instr_pc), 64'hFFFF);

    // Reset while stalled, with start and redirect in the same cycle.
    instr_ready = 1'b0;
    step();
    reset = 1'b1; start = 1'b1; redirect_valid = 1'b1; redirect_kind = 2'd2; redirect_reg = 64'h40;
    step();
    reset = 1'b0; start = 1'b0;
    chk("mr_valid", 64'(instr_valid), 64'd0);
    chk("mr_instr", 64'(instr), 64'd0);
    chk("mr_instr_pc", 64'(instr_pc), 64'd0);
    step();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    repeat (3) step();
    chk("mr_idle_pc", 64'(rom_address), 64'd0);
    chk("mr_idle_valid", 64'(instr_valid), 64'd0);

    // Random traffic with sparse halt words.
    for (int i = 0; i < 256; i++) rom[16'($urandom)] = HALT;
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      if (m_st == 2 && $urandom_range(0, 19) == 0) reset = 1'b1;
      start          = ($urandom_range(0, 3) == 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_kind  = 2'($urandom_range(0, 3));
      redirect_base  = 16'($urandom);
      redirect_imm   = 26'($urandom);
      redirect_reg   = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
